// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// pll_reset_sequencer_if : lock/soft-reset inputs and staged reset outputs
// Rev 1.0
// ============================================================================
interface pll_reset_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             soft_rst_req;
  logic             clear_status;
  logic             rst_vram_out;
  logic             rst_draw_out;
  logic             rst_cpu_out;
  logic             ready;
  logic             soft_rst_ack;
  logic             lock_lost;
  logic [CNT_W-1:0] lock_loss_count;

  modport master (
    output pll_locked, soft_rst_req, clear_status,
    input  rst_vram_out, rst_draw_out, rst_cpu_out, ready,
           soft_rst_ack, lock_lost, lock_loss_count
  );

  modport slave (
    input  pll_locked, soft_rst_req, clear_status,
    output rst_vram_out, rst_draw_out, rst_cpu_out, ready,
           soft_rst_ack, lock_lost, lock_loss_count
  );
endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// pll_reset_sequencer : syncs PLL lock, releases VRAM/draw/CPU resets in order
// Rev 1.0
// ============================================================================
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int HOLD_CYCLES        = 64,
  parameter int CNT_W              = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_reset_sequencer_if.slave  bus
);

  localparam int c_tmr_max = (LOCK_STABLE_CYCLES > STAGE_GAP)
                           ? ((LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES)
                           : ((STAGE_GAP > HOLD_CYCLES) ? STAGE_GAP : HOLD_CYCLES);
  localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

  localparam logic [c_tmr_w-1:0] c_stable_last = c_tmr_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_gap_last    = c_tmr_w'(STAGE_GAP - 1);
  localparam logic [c_tmr_w-1:0] c_hold_last   = c_tmr_w'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    REL_VRAM  = 3'd2,
    REL_DRAW  = 3'd3,
    RUN       = 3'd4,
    HOLD      = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [c_tmr_w-1:0] tmr_q, tmr_d;
  logic               sync1_q, sync1_d;
  logic               locked_s_q, locked_s_d;
  logic               rst_vram_q, rst_vram_d;
  logic               rst_draw_q, rst_draw_d;
  logic               rst_cpu_q, rst_cpu_d;
  logic               ready_q, ready_d;
  logic               ack_q, ack_d;
  logic               lost_q, lost_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               loss;

  always_comb begin
    sync1_d    = bus.pll_locked;
    locked_s_d = sync1_q;
    state_d    = state_q;
    tmr_d      = tmr_q;
    ack_d      = 1'b0;
    lost_d     = lost_q;
    cnt_d      = cnt_q;
    loss       = 1'b0;

    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = STABILIZE;
          tmr_d   = '0;
        end
      end
      STABILIZE: begin
        // a dropout here only restarts the wait; it is not a lock loss
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
        end else if (tmr_q == c_stable_last) begin
          state_d = REL_VRAM;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      REL_VRAM, REL_DRAW, RUN: begin
        if (!locked_s_q) begin
          loss = 1'b1;
        end else if (bus.soft_rst_req) begin
          state_d = HOLD;
          tmr_d   = '0;
          ack_d   = 1'b1;
        end else if (state_q != RUN) begin
          if (tmr_q == c_gap_last) begin
            state_d = (state_q == REL_VRAM) ? REL_DRAW : RUN;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // hold time counts from the last cycle the request was seen
        if (!locked_s_q) begin
          loss = 1'b1;
        end else if (bus.soft_rst_req) begin
          tmr_d = '0;
        end else if (tmr_q == c_hold_last) begin
          state_d = REL_VRAM;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        tmr_d   = '0;
      end
    endcase

    if (loss) begin
      state_d = WAIT_LOCK;
      tmr_d   = '0;
      lost_d  = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.clear_status) begin
      lost_d = 1'b0;
    end

    // outputs decode the next state so they are registered alongside it
    rst_vram_d = !(state_d inside {REL_VRAM, REL_DRAW, RUN});
    rst_draw_d = !(state_d inside {REL_DRAW, RUN});
    rst_cpu_d  = (state_d != RUN);
    ready_d    = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_LOCK;
      tmr_q      <= '0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      rst_vram_q <= 1'b1;
      rst_draw_q <= 1'b1;
      rst_cpu_q  <= 1'b1;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      lost_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      sync1_q    <= sync1_d;
      locked_s_q <= locked_s_d;
      rst_vram_q <= rst_vram_d;
      rst_draw_q <= rst_draw_d;
      rst_cpu_q  <= rst_cpu_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      lost_q     <= lost_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rst_vram_out    = rst_vram_q;
  assign bus.rst_draw_out    = rst_draw_q;
  assign bus.rst_cpu_out     = rst_cpu_q;
  assign bus.ready           = ready_q;
  assign bus.soft_rst_ack    = ack_q;
  assign bus.lock_lost       = lost_q;
  assign bus.lock_loss_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pll_reset_sequencer : timeline reference model feeding an output scoreboard
// Rev 1.0
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int LSC   = 16;
  localparam int GAP   = 4;
  localparam int HOLDC = 8;
  localparam int CNT_W = 8;
  localparam int VW    = CNT_W + 6;

  logic clk;
  logic rst;

  pll_reset_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (LSC),
    .STAGE_GAP          (GAP),
    .HOLD_CYCLES        (HOLDC),
    .CNT_W              (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] exp_q[$];

  function automatic logic [VW-1:0] pack(input logic v, input logic d, input logic c,
                                         input logic r, input logic a, input logic l,
                                         input logic [CNT_W-1:0] n);
    return {v, d, c, r, a, l, n};
  endfunction

  // Reference model: a release sequence is described by its start edge R,
  // every output is a simple comparison of the current edge against R.
  localparam int M_IDLE = 0, M_STAB = 1, M_REL = 2, M_HOLD = 3;
  int               m_mode;
  int unsigned      n_edge = 0;
  int unsigned      m_e, m_r, m_l;
  logic             p1, p2, ls, m_loss, m_ack, m_lost;
  int               m_cnt;
  logic             e_vram, e_draw, e_cpu;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_mode = M_IDLE;
      p1 = 1'b0; p2 = 1'b0;
      m_lost = 1'b0; m_cnt = 0; m_ack = 1'b0;
      exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0));
    end else begin
      n_edge++;
      ls = p2; p2 = p1; p1 = bus.pll_locked;
      m_loss = 1'b0;
      m_ack  = 1'b0;
      case (m_mode)
        M_IDLE: if (ls) begin m_mode = M_STAB; m_e = n_edge; end
        M_STAB: begin
          if (!ls) m_mode = M_IDLE;
          else if (n_edge == m_e + LSC) begin m_mode = M_REL; m_r = n_edge; end
        end
        M_REL: begin
          if (!ls) m_loss = 1'b1;
          else if (bus.soft_rst_req) begin m_mode = M_HOLD; m_l = n_edge; m_ack = 1'b1; end
        end
        default: begin
          if (!ls) m_loss = 1'b1;
          else if (bus.soft_rst_req) m_l = n_edge;
          else if (n_edge == m_l + HOLDC) begin m_mode = M_REL; m_r = n_edge; end
        end
      endcase
      if (m_loss) begin
        m_mode = M_IDLE;
        m_lost = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else if (bus.clear_status) begin
        m_lost = 1'b0;
      end
      e_vram = !(m_mode == M_REL);
      e_draw = !(m_mode == M_REL && n_edge >= m_r + GAP);
      e_cpu  = !(m_mode == M_REL && n_edge >= m_r + 2 * GAP);
      exp_q.push_back(pack(e_vram, e_draw, e_cpu, !e_cpu, m_ack, m_lost, CNT_W'(m_cnt)));
    end
  end

  // Monitor: compares whatever the DUT presents against the next expectation.
  logic [VW-1:0] act_v, exp_v;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = pack(bus.rst_vram_out, bus.rst_draw_out, bus.rst_cpu_out, bus.ready,
                   bus.soft_rst_ack, bus.lock_lost, bus.lock_loss_count);
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL outputs edge=%0d got vram,draw,cpu,ready,ack,lost=%b cnt=%0d want %b cnt=%0d",
                 n_edge, act_v[VW-1:CNT_W], act_v[CNT_W-1:0], exp_v[VW-1:CNT_W], exp_v[CNT_W-1:0]);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    bus.pll_locked   = 1'b1;
    bus.soft_rst_req = 1'b0;
    bus.clear_status = 1'b0;
    step(5);
    rst = 1'b0;
    step(35);

    // lock loss in RUN, then a one-cycle glitch during re-stabilisation
    bus.pll_locked = 1'b0; step(4);
    bus.pll_locked = 1'b1; step(10);
    bus.pll_locked = 1'b0; step(1);
    bus.pll_locked = 1'b1; step(40);

    // short soft reset in RUN
    bus.soft_rst_req = 1'b1; step(3);
    bus.soft_rst_req = 1'b0; step(30);

    // lock drop seen in the same cycle as a soft-reset request
    bus.pll_locked = 1'b0; step(2);
    bus.soft_rst_req = 1'b1; step(1);
    bus.soft_rst_req = 1'b0; step(3);
    bus.pll_locked = 1'b1; step(40);

    // clear_status colliding with a new loss, then clear_status alone
    bus.pll_locked = 1'b0; step(2);
    bus.clear_status = 1'b1; step(1);
    bus.clear_status = 1'b0; step(3);
    bus.pll_locked = 1'b1; step(40);
    bus.clear_status = 1'b1; step(1);
    bus.clear_status = 1'b0; step(3);

    // long soft reset, then one issued during REL_VRAM
    bus.soft_rst_req = 1'b1; step(12);
    bus.soft_rst_req = 1'b0; step(10);
    bus.soft_rst_req = 1'b1; step(1);
    bus.soft_rst_req = 1'b0; step(30);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (bus.pll_locked && $urandom_range(0, 79) == 0) bus.pll_locked = 1'b0;
      else if (!bus.pll_locked && $urandom_range(0, 3) == 0) bus.pll_locked = 1'b1;
      if ($urandom_range(0, 29) == 0) bus.soft_rst_req = ~bus.soft_rst_req;
      bus.clear_status = ($urandom_range(0, 19) == 0);
      step(1);
    end
    bus.soft_rst_req = 1'b0;
    bus.clear_status = 1'b0;

    // drive the loss counter into saturation
    for (int i = 0; i < 260; i++) begin
      bus.pll_locked = 1'b1; step(22);
      bus.pll_locked = 1'b0; step(3);
    end

    // async reset in the middle of REL_DRAW
    bus.pll_locked = 1'b1; step(24);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.rst_vram_out, bus.rst_draw_out, bus.rst_cpu_out, bus.ready, bus.lock_loss_count}
        !== {4'b1110, {CNT_W{1'b0}}}) begin
      bad++;
      $display("FAIL async_rst got vram,draw,cpu,ready=%b%b%b%b cnt=%0d want 1110 cnt=0",
               bus.rst_vram_out, bus.rst_draw_out, bus.rst_cpu_out, bus.ready, bus.lock_loss_count);
    end
    step(3);
    rst = 1'b0;
    step(35);

    total++;
    if (total < 1000) begin
      bad++;
      $display("FAIL scoreboard_activity got %0d comparisons want at least 1000", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the core PLL wrapper.
- Consumes the PLL `locked` output, which is asynchronous to this clock domain, and synchronizes it into the Uxn CPU / draw-queue clock (PLL output 2).
- Once lock has been stable long enough, releases three domain resets in a fixed order: VRAM, then draw queue, then CPU.
- Also re-sequences on a soft-reset request and records lock-loss events for status readback.

Parameters:
- LOCK_STABLE_CYCLES, 1024: cycles synchronized lock must stay high before the first release. Must be ≥1.
- STAGE_GAP, 16: cycles between successive reset releases. Must be ≥1.
- HOLD_CYCLES, 64: minimum cycles all resets are held after a soft-reset request. Must be ≥1.
- CNT_W, 8: width of the saturating lock-loss counter.

Ports:
- clk  in  1  sequencer clock (CPU/draw-queue PLL output)
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- soft_rst_req  in  1  level request to re-run the release sequence
- clear_status  in  1  single-cycle pulse; clears lock_lost
- rst_vram_out  out  1  active-high reset, VRAM domain
- rst_draw_out  out  1  active-high reset, draw queue
- rst_cpu_out  out  1  active-high reset, Uxn CPU
- ready  out  1  high only when all three resets are released
- soft_rst_ack  out  1  one-cycle pulse on entry to HOLD
- lock_lost  out  1  sticky; set when lock drops after release began
- lock_loss_count  out  CNT_W  saturating count of such drops

Behaviour:
- **Async reset (rst=1):**
  - Immediately forces rst_vram_out=rst_draw_out=rst_cpu_out=1, ready=0, soft_rst_ack=0, lock_lost=0, lock_loss_count=0.
  - Both synchronizer flops cleared; all counters cleared; state=WAIT_LOCK.
  - Applies mid-sequence with no exceptions.
- **Synchronizer:** 2-flop chain on pll_locked gives locked_s. All decisions use locked_s only.
- **All outputs are registered.** No output is a combinational function of the inputs.
- **State WAIT_LOCK:**
  - All resets asserted.
  - locked_s=1 → STABILIZE, with counter loaded to 0.
- **State STABILIZE:**
  - Counter increments each cycle.
  - locked_s=0 → WAIT_LOCK. This is not counted as a loss.
  - After LOCK_STABLE_CYCLES cycles → REL_VRAM; rst_vram_out falls on that edge.
- **Release timing:** if locked_s first reads high at edge E:
  - rst_vram_out falls at E+LOCK_STABLE_CYCLES.
  - rst_draw_out falls at E+LOCK_STABLE_CYCLES+STAGE_GAP.
  - rst_cpu_out and ready change at E+LOCK_STABLE_CYCLES+2·STAGE_GAP; state=RUN.
- **Release states:** REL_VRAM and REL_DRAW each last STAGE_GAP cycles before the next release.
- **Lock loss** (locked_s=0 in REL_VRAM, REL_DRAW, RUN or HOLD):
  - On the next edge: all resets=1, ready=0, state=WAIT_LOCK.
  - lock_lost is set.
  - lock_loss_count increments, saturating at 2^CNT_W−1 with no wrap.
- **Soft reset:**
  - soft_rst_req=1 in REL_VRAM, REL_DRAW or RUN → HOLD on the next edge: all resets=1, ready=0, soft_rst_ack=1 for exactly that one cycle.
  - HOLD lasts HOLD_CYCLES cycles. Its counter reloads to 0 every cycle soft_rst_req is still high, so it exits HOLD_CYCLES cycles after the request drops.
  - On exit, goes directly to REL_VRAM with no re-stabilize. Release gaps are as above.
  - soft_rst_req is ignored in WAIT_LOCK and STABILIZE.
- **Priorities:**
  - Lock loss beats soft_rst_req in the same cycle: goes to WAIT_LOCK, no ack, loss is counted.
  - Setting lock_lost beats clear_status in the same cycle.
  - clear_status never affects lock_loss_count.
- **Ordering invariants:**
  - rst_draw_out never deasserts while rst_vram_out=1.
  - rst_cpu_out never deasserts while rst_draw_out=1.
  - ready == !rst_cpu_out at all times.

Test Plan (LOCK_STABLE_CYCLES=16, STAGE_GAP=4, HOLD_CYCLES=8, CNT_W=8):
- Power-up: rst high 5 cycles, pll_locked high with locked_s first high at edge E → all resets high until E; vram low at E+16, draw low at E+20, cpu low and ready high at E+24; lock_loss_count=0.
- Glitch during stabilize: locked_s low for 1 cycle at E+10 → no release before the new E'+16; lock_lost=0; count=0.
- Lock loss in RUN: drop pll_locked → one edge after locked_s falls, all three resets=1, ready=0, lock_lost=1, count=1; relock → full 16/4/4 sequence repeats.
- Soft reset: 3-cycle soft_rst_req pulse in RUN → soft_rst_ack one cycle; resets held until 8 cycles after the request drops; then vram, draw, cpu release 4 cycles apart; count unchanged.
- Simultaneous events: lock drop coincident with soft_rst_req → no ack, count+1. clear_status coincident with a lock-loss set → lock_lost stays 1. clear_status alone → lock_lost 0, count unchanged.
- Saturation and async reset: force 260 losses → count holds at 255. Assert rst mid REL_DRAW → all resets high immediately (before the next clk edge), count=0.
